fuel_pump_guard: RTL
====================

Name: fuel_pump_guard

Overview:
Second-generation anti-theft fuel pump interlock for the automotive anti-theft system. It replaces the single hidden-switch check with a parametrised CODE_W-bit secret code that is entered under brake. It adds a failed-attempt counter with a timed lockout and alarm, plus a stall-recovery grace window. It sits between the ignition/brake/hidden-switch inputs and the fuel pump relay driver.

Parameters:
CODE_W, 4, width of hidden switch bus
SECRET, 4'b1011, required hidden_sw value (CODE_W bits)
MAX_TRIES, 3, failed attempts that trigger lockout (>=1)
LOCK_CYCLES, 20, clock cycles spent in LOCKED (>=1)
GRACE_CYCLES, 8, restart window after ignition drop in FUEL_ON; 0 disables grace

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ignition  in  1  ignition key on
brake  in  1  brake pedal pressed
hidden_sw  in  CODE_W  hidden code switches
code_enter  in  1  single-cycle strobe, samples the code attempt
fuel_pump  out  1  fuel pump relay enable
alarm  out  1  high while locked out
fail_count  out  $clog2(MAX_TRIES+1)  current consecutive failures
state_o  out  3  IDLE=0, IGN_ON=1, FUEL_ON=2, GRACE=3, LOCKED=4

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset (any time, including mid-lockout or mid-grace):
  - state goes to IDLE; timer and fail_count go to 0.
  - fuel_pump=0, alarm=0, state_o=0.
- Outputs decode the state register only:
  - fuel_pump=1 in FUEL_ON and GRACE.
  - alarm=1 in LOCKED.
  - There are no combinational paths from inputs to outputs.
- Timer width is $clog2(max(LOCK_CYCLES,GRACE_CYCLES)+1).
- IDLE:
  - ignition=1 -> IGN_ON next cycle.
  - fail_count is NOT cleared, so failures persist across key cycles.
- IGN_ON, in priority order:
  - ignition=0 -> IDLE.
  - code_enter=1 with brake=1 is an attempt:
    - hidden_sw==SECRET -> FUEL_ON; fail_count<=0.
    - Otherwise fail_count<=fail_count+1. If fail_count+1==MAX_TRIES -> LOCKED with timer<=LOCK_CYCLES-1, else stay in IGN_ON.
  - code_enter=1 with brake=0 is ignored (no count, no transition).
- FUEL_ON:
  - ignition=0 and GRACE_CYCLES>0 -> GRACE with timer<=GRACE_CYCLES-1.
  - ignition=0 and GRACE_CYCLES==0 -> IDLE.
  - brake, hidden_sw and code_enter are ignored.
- GRACE:
  - ignition=1 -> FUEL_ON with no code required. This has priority over expiry.
  - Else timer==0 -> IDLE.
  - Else timer decrements.
  - The pump stays on during GRACE for at most GRACE_CYCLES cycles.
- LOCKED:
  - All inputs are ignored, including ignition.
  - timer decrements each cycle.
  - When timer==0 -> IDLE and fail_count<=0.
  - alarm stays high for exactly LOCK_CYCLES cycles.
- fail_count never exceeds MAX_TRIES-1 outside LOCKED. It reads MAX_TRIES while in LOCKED.
- Unused state encodings (5-7) recover to IDLE next cycle with fuel_pump=0.

Test Plan:
- Reset release, ignition=1, brake=1, hidden_sw=4'b1011, code_enter pulse -> state 0->1->2; fuel_pump=1 on the cycle after the strobe; fail_count=0.
- In IGN_ON, strobe code_enter with brake=0 and wrong code 4'b0000 -> no count, fail_count=0, state stays 1.
- Three wrong strobes (4'b0001) under brake -> fail_count 1, then 2, then LOCKED. alarm=1 for exactly 20 cycles even with ignition toggling; then IDLE with fail_count=0.
- Two wrong attempts, ignition off and back on, one wrong attempt -> LOCKED (count persists across key cycles).
- FUEL_ON, drop ignition for 5 cycles, raise it -> fuel_pump stays 1 throughout, state returns to 2. Drop for 9 cycles -> fuel_pump falls after the 8th GRACE cycle and state goes to IDLE.
- Assert reset 10 cycles into LOCKED -> alarm=0, state_o=0, fail_count=0 immediately. A correct code after release yields fuel_pump=1.

Source files
------------

// File: rtl/fuel_pump_guard.sv
// Fuel pump interlock: secret code entered under brake enables the pump,
// repeated failures trigger a timed lockout with alarm, stalls get a restart grace window.
module fuel_pump_guard #(
    parameter int unsigned       CODE_W       = 4,
    parameter logic [CODE_W-1:0] SECRET       = 4'b1011,
    parameter int unsigned       MAX_TRIES    = 3,
    parameter int unsigned       LOCK_CYCLES  = 20,
    parameter int unsigned       GRACE_CYCLES = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             ignition,
    input  logic                             brake,
    input  logic [CODE_W-1:0]                hidden_sw,
    input  logic                             code_enter,
    output logic                             fuel_pump,
    output logic                             alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
    output logic [2:0]                       state_o
);

    localparam int unsigned TMR_MAX = (LOCK_CYCLES > GRACE_CYCLES) ? LOCK_CYCLES : GRACE_CYCLES;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);
    localparam int unsigned FW      = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IGN_ON  = 3'd1,
        FUEL_ON = 3'd2,
        GRACE   = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   fail_q,  fail_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        case (state_q)
            // fail count deliberately survives key-off so attempts accumulate across key cycles
            IDLE: begin
                if (ignition)
                    state_d = IGN_ON;
            end
            IGN_ON: begin
                if (!ignition) begin
                    state_d = IDLE;
                end else if (code_enter && brake) begin
                    if (hidden_sw == SECRET) begin
                        state_d = FUEL_ON;
                        fail_d  = '0;
                    end else begin
                        fail_d = fail_q + FW'(1);
                        if (fail_q == FW'(MAX_TRIES - 1)) begin
                            state_d = LOCKED;
                            timer_d = TW'(LOCK_CYCLES - 1);
                        end
                    end
                end
            end
            FUEL_ON: begin
                if (!ignition) begin
                    if (GRACE_CYCLES > 0) begin
                        state_d = GRACE;
                        timer_d = TW'(GRACE_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GRACE: begin
                if (ignition)
                    state_d = FUEL_ON;
                else if (timer_q == '0)
                    state_d = IDLE;
                else
                    timer_d = timer_q - TW'(1);
            end
            LOCKED: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fuel_pump = (state_q == FUEL_ON) || (state_q == GRACE);
        alarm     = (state_q == LOCKED);
    end

    assign state_o    = state_q;
    assign fail_count = fail_q;

endmodule
